// File: rtl/simd_pkg.sv
// simd_pkg: shared encodings and instruction field layout for the SIMD issue path
package simd_pkg;

    localparam int DEF_SIMD_WIDTH = 256;
    localparam int DEF_NREGS      = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SUBI = 4'd3;

    localparam logic [2:0] DM_8   = 3'd0;
    localparam logic [2:0] DM_16  = 3'd1;
    localparam logic [2:0] DM_32  = 3'd2;
    localparam logic [2:0] DM_64  = 3'd3;
    localparam logic [2:0] DM_128 = 3'd4;
    localparam logic [2:0] DM_256 = 3'd5;

    localparam int OP_LSB   = 28;
    localparam int MODE_LSB = 25;
    localparam int RD_LSB   = 22;
    localparam int RA_LSB   = 19;
    localparam int RB_LSB   = 16;
    localparam int IMM_LSB  = 0;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_SUBI;
    endfunction

endpackage

// File: rtl/simd_vreg_file.sv
// simd_vreg_file: vector register file with two async reads, one write, write-first bypass
module simd_vreg_file #(
    parameter int W = 256,
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [$clog2(N)-1:0] waddr_i,
    input  logic [W-1:0]         wdata_i,
    input  logic [$clog2(N)-1:0] raddr_a_i,
    input  logic [$clog2(N)-1:0] raddr_b_i,
    output logic [W-1:0]         rdata_a_o,
    output logic [W-1:0]         rdata_b_o
);

    logic [W-1:0] mem_q [N];

    // storage: cleared by reset, otherwise written on the strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (we_i && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
    assign rdata_b_o = (we_i && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];

endmodule

// File: rtl/simd_issue_stage.sv
// simd_issue_stage: decode, hazard scoreboard and registered operand bundle for simd_adder
module simd_issue_stage #(
    parameter int SIMD_WIDTH = simd_pkg::DEF_SIMD_WIDTH,
    parameter int NREGS      = simd_pkg::DEF_NREGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIMD_WIDTH-1:0]    A,
    output logic [SIMD_WIDTH-1:0]    B,
    output logic [2:0]               data_mode,
    output logic                     sub_flag,
    output logic                     imm_flag,
    output logic [7:0]               imm_reg,
    output logic [$clog2(NREGS)-1:0] out_rd,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [SIMD_WIDTH-1:0]    wb_data,
    output logic                     err_illegal
);

    import simd_pkg::*;

    localparam int IW = $clog2(NREGS);

    logic [3:0]            op;
    logic [2:0]            mode;
    logic [IW-1:0]         rd, ra, rb;
    logic [7:0]            imm;
    logic                  legal, is_imm, stall, xfer, issue;
    logic [NREGS-1:0]      pending_q, pending_d, pend_eff, wb_clr, issue_set;
    logic [SIMD_WIDTH-1:0] rdata_a, rdata_b;
    logic                  valid_q, valid_d, err_q;
    logic [SIMD_WIDTH-1:0] a_q, b_q;
    logic [2:0]            mode_q;
    logic                  sub_q, immf_q;
    logic [7:0]            immr_q;
    logic [IW-1:0]         rd_q;

    assign op     = in_instr[OP_LSB +: 4];
    assign mode   = in_instr[MODE_LSB +: 3];
    assign rd     = in_instr[RD_LSB +: IW];
    assign ra     = in_instr[RA_LSB +: IW];
    assign rb     = in_instr[RB_LSB +: IW];
    assign imm    = in_instr[IMM_LSB +: 8];
    assign legal  = is_legal(op);
    assign is_imm = op[1];

    simd_vreg_file #(.W(SIMD_WIDTH), .N(NREGS)) u_vrf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (ra),
        .raddr_b_i (rb),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b)
    );

    // hazards are judged after this cycle's writeback clear so a returning result unblocks immediately
    always_comb begin
        wb_clr    = wb_en ? (NREGS'(1) << wb_addr) : '0;
        pend_eff  = pending_q & ~wb_clr;
        stall     = legal & (pend_eff[ra] | (~is_imm & pend_eff[rb]) | pend_eff[rd]);
        in_ready  = ~stall & (~valid_q | out_ready);
        xfer      = in_valid & in_ready;
        issue     = xfer & legal;
        issue_set = issue ? (NREGS'(1) << rd) : '0;
        pending_d = pend_eff | issue_set;
        valid_d   = issue | (valid_q & ~out_ready);
    end

    // scoreboard, output bundle and illegal-op pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= '0;
            sub_q     <= 1'b0;
            immf_q    <= 1'b0;
            immr_q    <= '0;
            rd_q      <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            err_q     <= xfer & ~legal;
            if (issue) begin
                a_q    <= rdata_a;
                b_q    <= is_imm ? '0 : rdata_b;
                mode_q <= mode;
                sub_q  <= op[0];
                immf_q <= is_imm;
                immr_q <= imm;
                rd_q   <= rd;
            end
        end
    end

    assign out_valid   = valid_q;
    assign err_illegal = err_q;
    assign A           = a_q;
    assign B           = b_q;
    assign data_mode   = mode_q;
    assign sub_flag    = sub_q;
    assign imm_flag    = immf_q;
    assign imm_reg     = immr_q;
    assign out_rd      = rd_q;

endmodule
